uart_sd_sector_buffer: RTL and testbench

- Sits directly upstream of the SD-card write controller, between the UART byte receiver and the SD write interface.
- Packs received UART bytes into 512-byte sectors inside a ping-pong buffer of two banks, each 256 × 16-bit.
- Hands each completed sector to the SD write controller using the controller's wr_en / wr_busy / wr_req word handshake, at auto-incrementing sector addresses.
- A partial sector is flushed after a programmable UART idle time.

---
 rtl/sd_buf_pkg.sv | 26 ++
 rtl/sd_wr_bank_ram.sv | 25 ++
 rtl/uart_sd_sector_buffer.sv | 170 +++++++++++++++++
 tb/tb_uart_sd_sector_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_buf_pkg.sv
// Shared constants for the UART-to-SD sector buffer: sector geometry,
// read FSM state encodings, bank status encodings and a byte-to-word helper.
// No ports; imported by uart_sd_sector_buffer and sd_wr_bank_ram users.
package sd_buf_pkg;

  localparam int WORDS_PER_SECTOR = 256;
  localparam int BYTES_PER_SECTOR = 512;

  // Read FSM states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_XFER      = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  // Bank status
  localparam logic BANK_FREE  = 1'b0;
  localparam logic BANK_READY = 1'b1;

  // Number of 16-bit words occupied by n bytes (a trailing odd byte takes a word).
  function automatic logic [8:0] words_for_bytes(input logic [8:0] n);
    logic [9:0] w_sum;
    w_sum = {1'b0, n} + 10'd1;
    return w_sum[9:1];
  endfunction

endpackage

// File: rtl/sd_wr_bank_ram.sv
// 512 x 16 simple dual-port RAM holding both sector banks (address bit 8 = bank).
// Ports: clk; write port i_we/i_waddr/i_wdata; read port i_raddr -> o_rdata.
// Read is registered: o_rdata shows mem[i_raddr] one cycle after the address.
module sd_wr_bank_ram (
  input  logic        clk,
  input  logic        i_we,
  input  logic [8:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [8:0]  i_raddr,
  output logic [15:0] o_rdata
);

  logic [15:0] r_mem [0:511];
  logic [15:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_sd_sector_buffer.sv
// Packs UART bytes into 512-byte sectors in a two-bank ping-pong buffer and
// hands each sector to the SD write controller (wr_en / wr_busy / wr_req).
// Ports: sys_clk, sys_rst_n (sync, active-high); rx_data/rx_flag byte input;
// wr_busy/wr_req from SD controller; wr_en/wr_addr/wr_data, overflow, sectors_written out.
module uart_sd_sector_buffer
  import sd_buf_pkg::*;
#(
  parameter logic [31:0] START_SECTOR = 32'd16384,
  parameter logic [7:0]  PAD_BYTE     = 8'h00,
  parameter int          IDLE_TIMEOUT = 2_500_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_flag,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        overflow,
  output logic [15:0] sectors_written
);

  localparam logic [31:0] LP_IDLE_MAX = 32'(IDLE_TIMEOUT);

  // Fill side
  logic        r_wr_bank;
  logic [8:0]  r_byte_cnt;
  logic [7:0]  r_hi;
  logic [1:0]  r_bank_st;
  logic [8:0]  r_valid_words [0:1];
  logic [31:0] r_idle_cnt;
  logic        r_overflow;

  // Read side
  logic [1:0]  r_state;
  logic        r_rd_bank;
  logic [7:0]  r_k;
  logic        r_wr_en;
  logic [31:0] r_wr_addr;
  logic [15:0] r_sectors;

  logic        w_free_evt, w_wb_free, w_accept, w_drop, w_timeout;
  logic        w_sector_full, w_seal, w_start, w_req_take, w_rd_bank_next;
  logic [8:0]  w_seal_words;
  logic [7:0]  w_k_next;
  logic        w_ram_we;
  logic [15:0] w_ram_wdata, w_ram_q;

  // A bank being released this cycle may take a byte in the same cycle.
  assign w_free_evt = (r_state == ST_DONE) && !wr_busy;
  assign w_wb_free  = (r_bank_st[r_wr_bank] == BANK_FREE) ||
                      (w_free_evt && (r_rd_bank == r_wr_bank));
  assign w_accept   = rx_flag && w_wb_free;
  assign w_drop     = rx_flag && !w_wb_free;
  assign w_timeout  = !rx_flag && (r_idle_cnt == LP_IDLE_MAX) && (r_byte_cnt != 9'd0);

  assign w_sector_full = w_accept && (r_byte_cnt == 9'(BYTES_PER_SECTOR - 1));
  assign w_seal        = w_sector_full || w_timeout;
  assign w_seal_words  = w_sector_full ? 9'(WORDS_PER_SECTOR) : words_for_bytes(r_byte_cnt);

  // Odd byte completes a word; on timeout a pending high byte is padded.
  assign w_ram_we    = r_byte_cnt[0] && (w_accept || w_timeout);
  assign w_ram_wdata = {r_hi, (w_accept ? rx_data : PAD_BYTE)};

  assign w_start    = (r_state == ST_IDLE) && (r_bank_st[r_rd_bank] == BANK_READY) && !wr_busy;
  assign w_req_take = (r_state == ST_XFER) && wr_req;

  // The RAM is addressed with next-cycle values so its registered output
  // always matches the current (bank, word index) pair.
  assign w_k_next       = w_free_evt ? 8'd0 :
                          (w_req_take && (r_k != 8'hFF)) ? r_k + 8'd1 : r_k;
  assign w_rd_bank_next = w_free_evt ? ~r_rd_bank : r_rd_bank;

  sd_wr_bank_ram u_ram (
    .clk     (sys_clk),
    .i_we    (w_ram_we),
    .i_waddr ({r_wr_bank, r_byte_cnt[8:1]}),
    .i_wdata (w_ram_wdata),
    .i_raddr ({w_rd_bank_next, w_k_next}),
    .o_rdata (w_ram_q)
  );

  assign wr_en           = r_wr_en;
  assign wr_addr         = r_wr_addr;
  assign overflow        = r_overflow;
  assign sectors_written = r_sectors;
  assign wr_data = (r_state == ST_IDLE) ? 16'h0000 :
                   ({1'b0, r_k} >= r_valid_words[r_rd_bank]) ? {PAD_BYTE, PAD_BYTE} : w_ram_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      r_wr_bank        <= 1'b0;
      r_byte_cnt       <= 9'd0;
      r_hi             <= 8'h00;
      r_bank_st        <= {BANK_FREE, BANK_FREE};
      r_valid_words[0] <= 9'd0;
      r_valid_words[1] <= 9'd0;
      r_idle_cnt       <= 32'd0;
      r_overflow       <= 1'b0;
      r_state          <= ST_IDLE;
      r_rd_bank        <= 1'b0;
      r_k              <= 8'd0;
      r_wr_en          <= 1'b0;
      r_wr_addr        <= START_SECTOR;
      r_sectors        <= 16'd0;
    end else begin
      if (rx_flag) begin
        r_idle_cnt <= 32'd0;
      end else if (r_idle_cnt != LP_IDLE_MAX) begin
        r_idle_cnt <= r_idle_cnt + 32'd1;
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_accept && !r_byte_cnt[0]) begin
        r_hi <= rx_data;
      end

      if (w_seal) begin
        r_byte_cnt                <= 9'd0;
        r_wr_bank                 <= ~r_wr_bank;
        r_valid_words[r_wr_bank]  <= w_seal_words;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 9'd1;
      end

      // Release first, then seal: a same-cycle seal of the just-freed bank wins.
      if (w_free_evt) begin
        r_bank_st[r_rd_bank] <= BANK_FREE;
      end
      if (w_seal) begin
        r_bank_st[r_wr_bank] <= BANK_READY;
      end

      r_wr_en   <= 1'b0;
      r_k       <= w_k_next;
      r_rd_bank <= w_rd_bank_next;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_wr_en <= 1'b1;
            r_state <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (wr_busy) begin
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (wr_req && (r_k == 8'hFF)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!wr_busy) begin
            r_state   <= ST_IDLE;
            r_wr_addr <= r_wr_addr + 32'd1;
            r_sectors <= r_sectors + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sd_sector_buffer.sv
// Bench for uart_sd_sector_buffer: SD controller model plus scoreboard.
// Expected sectors are built from the byte stream and checked word by word.
// Ports: none.
module tb_uart_sd_sector_buffer;

  localparam logic [31:0] START  = 32'd16384;
  localparam logic [7:0]  PAD    = 8'h00;
  localparam int          IDLE_T = 300;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_flag = 1'b0;
  logic        wr_busy = 1'b0;
  logic        wr_req = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [15:0] wr_data;
  logic        overflow;
  logic [15:0] sectors_written;

  uart_sd_sector_buffer #(
    .START_SECTOR (START),
    .PAD_BYTE     (PAD),
    .IDLE_TIMEOUT (IDLE_T)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .rx_data         (rx_data),
    .rx_flag         (rx_flag),
    .wr_busy         (wr_busy),
    .wr_req          (wr_req),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .overflow        (overflow),
    .sectors_written (sectors_written)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  // Reference model
  logic [7:0]  cur_bytes[$];
  logic [15:0] exp_words[$];
  logic [31:0] exp_addrs[$];
  logic [31:0] m_next_addr = START;
  int          m_filled = 0;
  int          mon_drained = 0;
  bit          m_overflow = 1'b0;

  // SD model controls
  int sd_gap = -1;
  bit sd_hold = 1'b0;

  // Monitor state
  bit mon_active = 1'b0;
  int mon_words = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sector = the bytes received, padded to 512, paired big-endian into words.
  task automatic model_seal();
    while (cur_bytes.size() < 512) cur_bytes.push_back(PAD);
    for (int i = 0; i < 256; i++) exp_words.push_back({cur_bytes[2*i], cur_bytes[2*i+1]});
    exp_addrs.push_back(m_next_addr);
    m_next_addr++;
    m_filled++;
    cur_bytes.delete();
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    acc = (m_filled - mon_drained) < 2;
    rx_data = b;
    rx_flag = 1'b1;
    step();
    rx_flag = 1'b0;
    if (acc) begin
      cur_bytes.push_back(b);
      if (cur_bytes.size() == 512) model_seal();
    end else begin
      m_overflow = 1'b1;
    end
    repeat (gap) step();
  endtask

  task automatic send_random(input int n, input int maxgap);
    for (int i = 0; i < n; i++) send_byte(8'($urandom), $urandom_range(0, maxgap));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(exp_words.size() == 0 && !mon_active && !wr_busy &&
             sectors_written == 16'(m_filled)) && n < 8000) begin
      step();
      n++;
    end
    repeat (3) step();
    check({name, "_timeout"}, 32'(n < 8000), 32'd1);
    check({name, "_sectors"}, 32'(sectors_written), 32'(m_filled));
    check({name, "_overflow"}, 32'(overflow), 32'(m_overflow));
    check({name, "_words_left"}, 32'(exp_words.size()), 32'd0);
  endtask

  // SD write controller model: acknowledges wr_en with busy, then issues 256 wr_req.
  initial begin
    int g;
    forever begin
      step();
      if (sd_hold) begin
        wr_busy = 1'b1;
      end else if (wr_en) begin
        wr_busy = 1'b1;
        step();
        for (int k = 0; k < 256; k++) begin
          g = (sd_gap < 0) ? int'($urandom_range(0, 3)) : sd_gap;
          if (g > 0) begin
            wr_req = 1'b0;
            repeat (g) step();
          end
          wr_req = 1'b1;
          step();
        end
        wr_req = 1'b0;
        repeat (2) step();
        wr_busy = 1'b0;
      end else begin
        wr_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every wr_en and every consumed word.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        mon_active = 1'b0;
        mon_words = 0;
      end else begin
        if (wr_en) begin
          if (exp_addrs.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_wr_en: got addr %0h expected no write", wr_addr);
          end else begin
            check("wr_addr", wr_addr, exp_addrs.pop_front());
          end
          mon_active = 1'b1;
          mon_words = 0;
        end
        if (wr_req && mon_active) begin
          if (exp_words.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_word: got %0h expected none", wr_data);
          end else begin
            check($sformatf("wr_data[%0d]", mon_words), 32'(wr_data), 32'(exp_words.pop_front()));
          end
          mon_words++;
          if (mon_words == 256) begin
            mon_active = 1'b0;
            mon_drained++;
          end
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge sys_clk);
    $display("FAIL watchdog: got no finish expected finish within 90000 cycles");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) step();
    sys_rst_n = 1'b0;
    step();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", wr_addr, START);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_sectors", 32'(sectors_written), 32'd0);

    // 1: ascending byte ramp twice -> 0001, 0203 ... FEFF repeated
    for (int i = 0; i < 512; i++) send_byte(8'(i), $urandom_range(0, 2));
    wait_drain("ramp");

    // 2: 1024 bytes streamed while sector 0 transfers
    send_random(1024, 1);
    wait_drain("stream");

    // 3: partial sector flushed by idle timeout -> AABB, CC00, zeros
    send_byte(8'hAA, 2);
    send_byte(8'hBB, 2);
    send_byte(8'hCC, 0);
    model_seal();
    wait_drain("flush");

    // 4: SD permanently busy; the 1025th byte is dropped
    sd_hold = 1'b1;
    repeat (3) step();
    send_random(1024, 0);
    step();
    check("hold_ovf_before", 32'(overflow), 32'(m_overflow));
    send_byte(8'h5A, 1);
    check("hold_ovf_after", 32'(overflow), 32'(m_overflow));
    check("hold_ovf_one", 32'(overflow), 32'd1);
    sd_hold = 1'b0;
    wait_drain("hold");

    // 5: wr_req every cycle, then every 7 cycles
    sd_gap = 0;
    send_random(512, 2);
    wait_drain("req_b2b");
    sd_gap = 6;
    send_random(512, 2);
    wait_drain("req_gap7");
    sd_gap = -1;

    // 6: reset in the middle of a transfer
    send_random(512, 1);
    n = 0;
    while (!(mon_active && mon_words >= 100) && n < 5000) begin
      step();
      n++;
    end
    check("reach_word100", 32'(n < 5000), 32'd1);
    sys_rst_n = 1'b1;
    step();
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_addr", wr_addr, START);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_sectors", 32'(sectors_written), 32'd0);
    sys_rst_n = 1'b0;
    exp_words.delete();
    exp_addrs.delete();
    cur_bytes.delete();
    m_next_addr = START;
    m_filled = 0;
    mon_drained = 0;
    m_overflow = 1'b0;
    send_random(512, 1);
    wait_drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
